fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_hold_buf.sv | 27 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants for the instruction fetch unit.
//   RESET_PC_DEF : default first fetch address after reset
//   NOP          : addi x0,x0,0, presented to decode when no word is valid
//   ST_*         : 2-bit fetch FSM state encoding
//   word_align() : clears byte-offset bits of an address
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_2000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  localparam logic [1:0] ST_BOOT = 2'd0;  // fetch issued, no data yet
  localparam logic [1:0] ST_RUN  = 2'd1;  // data arriving from imem
  localparam logic [1:0] ST_HOLD = 2'd2;  // word parked in hold register

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: single-word hold register with bypass mux.
//   clk, rst  : clock, async active-high reset (hold resets to NOP)
//   capture   : load data_in into the hold register
//   data_in   : live instruction word from imem
//   sel_hold  : 1 = present held word, 0 = pass data_in through
//   data_out  : selected instruction word
module fetch_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic [31:0] data_in,
  input  logic        sel_hold,
  output logic [31:0] data_out
);

  logic [31:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hold_q <= NOP;
    else if (capture) hold_q <= data_in;
  end

  assign data_out = sel_hold ? hold_q : data_in;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for a synchronous (1-cycle) imem.
//   clk, rst          : clock, async active-high reset
//   stall             : decode did not accept the current if_* word
//   redirect_valid/pc : resolved taken branch / JAL / JALR target
//   imem_addr/re      : word-aligned fetch address and read enable
//   imem_rdata        : word returned one cycle after an enabled address
//   if_pc/inst/valid  : fetched PC/instruction pair presented to decode
// A word that arrives while decode is stalled is parked in the hold buffer
// and memory reads are suppressed, so the refetch-free resume has no bubble.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;     // address issued this cycle
  logic [31:0] pc_inf_q, pc_inf_d; // address issued the previous cycle
  logic        re_c;
  logic        capture;
  logic [31:0] buf_out;

  // Byte-offset bits of the target are dropped by design; no trap here.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d  = state_q;
    pc_f_d   = pc_f_q;
    pc_inf_d = pc_inf_q;
    re_c     = 1'b0;
    capture  = 1'b0;
    if (redirect_valid) begin
      // Redirect beats stall; the in-flight read is squashed by not issuing
      // one this cycle and by restarting in BOOT (if_valid=0).
      state_d  = ST_BOOT;
      pc_f_d   = word_align(redirect_pc);
      pc_inf_d = word_align(redirect_pc);
    end else begin
      case (state_q)
        ST_BOOT: begin
          re_c     = 1'b1;
          pc_inf_d = pc_f_q;
          pc_f_d   = pc_f_q + 32'd4;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end else begin
            re_c     = 1'b1;
            pc_inf_d = pc_f_q;
            pc_f_d   = pc_f_q + 32'd4;
          end
        end
        ST_HOLD: begin
          // Held word goes out now while the next address is issued.
          if (!stall) begin
            re_c     = 1'b1;
            pc_inf_d = pc_f_q;
            pc_f_d   = pc_f_q + 32'd4;
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_f_q   <= RESET_PC;
      pc_inf_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_f_q   <= pc_f_d;
      pc_inf_q <= pc_inf_d;
    end
  end

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .data_in  (imem_rdata),
    .sel_hold (state_q == ST_HOLD),
    .data_out (buf_out)
  );

  // rst gates the read enable directly so it drops without waiting for clk.
  assign imem_re   = re_c & ~rst;
  assign imem_addr = pc_f_q;
  assign if_pc     = pc_inf_q;
  assign if_valid  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign if_inst   = (state_q == ST_BOOT) ? NOP : buf_out;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit. The memory model returns
// {addr[15:0], ~addr[15:0]} for enabled reads and garbage otherwise, so any
// use of a stale imem_rdata instead of the hold register shows up.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_re        (imem_re),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_valid       (if_valid)
  );

  always @(posedge clk) begin
    if (imem_re) imem_rdata <= {imem_addr[15:0], ~imem_addr[15:0]};
    else         imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag, input logic v, input logic re,
                     input logic [31:0] addr, input logic [31:0] pc,
                     input logic [31:0] inst);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".re"},    {31'd0, imem_re},  {31'd0, re});
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".pc"},    if_pc, pc);
    chk({tag, ".inst"},  if_inst, inst);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    out("rst", 1'b0, 1'b0, 32'h2000, 32'h2000, 32'h0000_0013);
    step(); step();
    rst = 1'b0; #2;
    out("boot", 1'b0, 1'b1, 32'h2000, 32'h2000, 32'h0000_0013);
    step(); #2;
    out("run0", 1'b1, 1'b1, 32'h2004, 32'h2000, 32'h2000_DFFF);
    step(); stall = 1'b1; #2;
    out("stl0", 1'b1, 1'b0, 32'h2008, 32'h2004, 32'h2004_DFFB);
    step(); #2;
    out("stl1", 1'b1, 1'b0, 32'h2008, 32'h2004, 32'h2004_DFFB);
    step(); #2;
    out("stl2", 1'b1, 1'b0, 32'h2008, 32'h2004, 32'h2004_DFFB);
    step(); stall = 1'b0; #2;
    out("rel", 1'b1, 1'b1, 32'h2008, 32'h2004, 32'h2004_DFFB);
    step(); #2;
    out("run1", 1'b1, 1'b1, 32'h200C, 32'h2008, 32'h2008_DFF7);
    // redirect to a misaligned target
    step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_3002; #2;
    chk("rd.re", {31'd0, imem_re}, 32'd0);
    step(); redirect_valid = 1'b0; #2;
    out("rd1", 1'b0, 1'b1, 32'h3000, 32'h3000, 32'h0000_0013);
    step(); #2;
    out("rd2", 1'b1, 1'b1, 32'h3004, 32'h3000, 32'h3000_CFFF);
    step(); stall = 1'b1; #2;
    chk("rd3.pc", if_pc, 32'h3004);
    // redirect + stall together while in HOLD
    step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #2;
    chk("hr.inst", if_inst, 32'h3004_CFFB);
    chk("hr.re", {31'd0, imem_re}, 32'd0);
    step(); redirect_valid = 1'b0; stall = 1'b0; #2;
    out("wr0", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0013);
    step(); #2;
    out("wr1", 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFC_0003);
    step(); stall = 1'b1; #2;
    out("wr2", 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_FFFF);
    // reset pulse between edges while in HOLD
    step(); #2;
    chk("mh.valid", {31'd0, if_valid}, 32'd1);
    rst = 1'b1; #1;
    out("arst", 1'b0, 1'b0, 32'h2000, 32'h2000, 32'h0000_0013);
    step(); rst = 1'b0; stall = 1'b0; #2;
    out("rb", 1'b0, 1'b1, 32'h2000, 32'h2000, 32'h0000_0013);
    step(); #2;
    out("rr", 1'b1, 1'b1, 32'h2004, 32'h2000, 32'h2000_DFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
